// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: operand forwarding selects, load-use bubble
// insertion and whole-pipe freeze while data memory is busy.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs2,
  input  logic [4:0]       Rt2,
  input  logic [4:0]       Rd3,
  input  logic [4:0]       Rt3,
  input  logic [4:0]       Rd4,
  input  logic [4:0]       Rt4,
  input  logic [1:0]       ALUOp2,
  input  logic [1:0]       ALUOp3,
  input  logic [1:0]       ALUOp4,
  input  logic             mem_busy,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_ex,
  output logic             bubble,
  output logic             wait_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [15:0] WAIT_LIMIT = 16'(MAX_WAIT);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;

  state_t      state, stateNext;
  logic        useRs, useRt, loadUse;
  logic [15:0] waitCnt, waitCntInc;

  // Youngest producer wins: stage 3 ALU result beats anything sitting in stage 4.
  function automatic logic [1:0] fwdSel(input logic [4:0] src, input logic used,
                                        input logic [1:0] op3, input logic [4:0] rd3,
                                        input logic [1:0] op4, input logic [4:0] rd4,
                                        input logic [4:0] rt4);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && src != 5'd0) begin
      if (op3 == OP_ALU && rd3 == src)
        sel = 2'b01;
      else if (op4 == OP_ALU && rd4 == src)
        sel = 2'b10;
      else if (op4 == OP_LD && rt4 == src)
        sel = 2'b11;
    end
    return sel;
  endfunction

  always_comb begin
    useRs   = (ALUOp2 == OP_LD) || (ALUOp2 == OP_ST) || (ALUOp2 == OP_ALU);
    useRt   = (ALUOp2 == OP_ST) || (ALUOp2 == OP_ALU);
    loadUse = (ALUOp3 == OP_LD) && (Rt3 != 5'd0) &&
              ((useRs && Rs2 == Rt3) || (useRt && Rt2 == Rt3));
  end

  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (rst_n) begin
      fwdA = fwdSel(Rs2, useRs, ALUOp3, Rd3, ALUOp4, Rd4, Rt4);
      fwdB = fwdSel(Rt2, useRt, ALUOp3, Rd3, ALUOp4, Rd4, Rt4);
    end
  end

  // Memory freeze outranks load-use; a load-use check right after its own bubble is suppressed.
  always_comb begin
    stateNext  = RUN;
    stall_pc   = 1'b0;
    stall_ifid = 1'b0;
    stall_ex   = 1'b0;
    bubble     = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        stall_ex   = 1'b1;
        stateNext  = MEMWAIT;
      end else if (state != LDSTALL && loadUse) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        bubble     = 1'b1;
        stateNext  = LDSTALL;
      end
    end
  end

  assign waitCntInc = (waitCnt >= WAIT_LIMIT) ? waitCnt : waitCnt + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= RUN;
      waitCnt      <= 16'd0;
      wait_timeout <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= stateNext;
      if (mem_busy) begin
        waitCnt <= waitCntInc;
        if (waitCntInc >= WAIT_LIMIT)
          wait_timeout <= 1'b1;
      end else begin
        waitCnt <= 16'd0;
      end
      if (stall_pc && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios then randomized traffic,
// each cycle's expected response queued by the stimulus side and popped by a negedge monitor.
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 6;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       Rs2, Rt2, Rd3, Rt3, Rd4, Rt4;
  logic [1:0]       ALUOp2, ALUOp3, ALUOp4;
  logic             mem_busy;
  logic [1:0]       fwdA, fwdB;
  logic             stall_pc, stall_ifid, stall_ex, bubble, wait_timeout;
  logic [CNT_W-1:0] stall_cycles;

  typedef struct packed {
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             sp;
    logic             si;
    logic             se;
    logic             bu;
    logic             to;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model state: whether last cycle inserted a load bubble, current busy streak,
  // sticky timeout and the stall tally.
  bit mAfterBubble = 0;
  int mBusyRun     = 0;
  bit mTimeout     = 0;
  int mStalls      = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs2(Rs2), .Rt2(Rt2), .Rd3(Rd3), .Rt3(Rt3), .Rd4(Rd4), .Rt4(Rt4),
    .ALUOp2(ALUOp2), .ALUOp3(ALUOp3), .ALUOp4(ALUOp4), .mem_busy(mem_busy),
    .fwdA(fwdA), .fwdB(fwdB), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_ex(stall_ex), .bubble(bubble), .wait_timeout(wait_timeout),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] modelFwd(input logic [4:0] src, input bit used,
                                          input logic [1:0] op3, input logic [4:0] rd3,
                                          input logic [1:0] op4, input logic [4:0] rd4,
                                          input logic [4:0] rt4);
    if (!used || src == 0) return 2'd0;
    if (op3 == 2 && rd3 == src) return 2'd1;
    if (op4 == 2 && rd4 == src) return 2'd2;
    if (op4 == 0 && rt4 == src) return 2'd3;
    return 2'd0;
  endfunction

  task automatic applyStimulus(input logic rn, input logic busy,
                               input logic [1:0] op2, input logic [1:0] op3, input logic [1:0] op4,
                               input logic [4:0] rs2, input logic [4:0] rt2, input logic [4:0] rd3,
                               input logic [4:0] rt3, input logic [4:0] rd4, input logic [4:0] rt4);
    exp_t e;
    bit   rsUsed, rtUsed, hit, ldStall, anyStall;
    @(posedge clk);
    #1;
    rst_n = rn; mem_busy = busy;
    ALUOp2 = op2; ALUOp3 = op3; ALUOp4 = op4;
    Rs2 = rs2; Rt2 = rt2; Rd3 = rd3; Rt3 = rt3; Rd4 = rd4; Rt4 = rt4;

    rsUsed  = (op2 != 3);
    rtUsed  = (op2 == 1 || op2 == 2);
    hit     = (op3 == 0) && (rt3 != 0) && ((rsUsed && rs2 == rt3) || (rtUsed && rt2 == rt3));
    ldStall = rn && !busy && hit && !mAfterBubble;
    anyStall = rn && (busy || ldStall);

    e    = '0;
    e.to = mTimeout;
    e.sc = CNT_W'(mStalls);
    if (rn) begin
      e.fa = modelFwd(rs2, rsUsed, op3, rd3, op4, rd4, rt4);
      e.fb = modelFwd(rt2, rtUsed, op3, rd3, op4, rd4, rt4);
      e.sp = anyStall;
      e.si = anyStall;
      e.se = busy;
      e.bu = ldStall;
    end
    expQ.push_back(e);

    if (!rn) begin
      mAfterBubble = 0; mBusyRun = 0; mTimeout = 0; mStalls = 0;
    end else begin
      if (anyStall && mStalls < CNT_MAX) mStalls++;
      mBusyRun = busy ? mBusyRun + 1 : 0;
      if (mBusyRun >= MAX_WAIT) mTimeout = 1;
      mAfterBubble = ldStall;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, cycle, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("fwdA", 16'(fwdA), 16'(e.fa));
      checkOutput("fwdB", 16'(fwdB), 16'(e.fb));
      checkOutput("stall_pc", 16'(stall_pc), 16'(e.sp));
      checkOutput("stall_ifid", 16'(stall_ifid), 16'(e.si));
      checkOutput("stall_ex", 16'(stall_ex), 16'(e.se));
      checkOutput("bubble", 16'(bubble), 16'(e.bu));
      checkOutput("wait_timeout", 16'(wait_timeout), 16'(e.to));
      checkOutput("stall_cycles", 16'(stall_cycles), 16'(e.sc));
      cycle++;
    end
  end

  initial begin
    logic busyR;
    rst_n = 0; mem_busy = 0;
    ALUOp2 = 3; ALUOp3 = 3; ALUOp4 = 3;
    Rs2 = 0; Rt2 = 0; Rd3 = 0; Rt3 = 0; Rd4 = 0; Rt4 = 0;
    repeat (2) @(posedge clk);

    // reset cycle with a live load-use hazard, then idle
    applyStimulus(0, 1, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    // forwarding priority: stage 3 ALU beats stage 4 ALU
    applyStimulus(1, 0, 2, 2, 2, 5, 6, 5, 0, 5, 0);
    // load-use: bubble, then load data forwarded from stage 4
    applyStimulus(1, 0, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 2, 3, 0, 1, 7, 0, 0, 0, 7);
    applyStimulus(1, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    // register 0 never hazards; Rt unused by a load
    applyStimulus(1, 0, 2, 0, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 3, 3, 7, 0, 7, 0, 0);
    // memory wait during a load-use hazard, then the bubble
    repeat (3) applyStimulus(1, 1, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 2, 3, 0, 1, 7, 0, 0, 0, 7);
    applyStimulus(1, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    // long wait trips the sticky timeout
    repeat (6) applyStimulus(1, 1, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    repeat (2) applyStimulus(1, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    // reset during the bubble cycle; after release the same hazard stalls again
    applyStimulus(1, 0, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(0, 1, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    // reset during a memory wait
    repeat (2) applyStimulus(1, 1, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 0, 3, 1, 7, 0, 7, 0, 0);
    applyStimulus(1, 0, 3, 3, 3, 0, 0, 0, 0, 0, 0);

    // randomized traffic over a small register range so hazards are frequent
    busyR = 0;
    for (int i = 0; i < 600; i++) begin
      busyR = busyR ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0);
      applyStimulus(($urandom_range(0, 59) != 0), busyR,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
